// File: rtl/write_back_unit_if.sv
// Writeback-stage bus: MEM-side instruction handshake, data-memory response, and register-file write port.
// Latency: none, plain wires between the MEM stage, the writeback unit and the register file.
// Backpressure: ready_o is the only backpressure signal; the register-file write side has none.
package write_back_unit_pkg;
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2,
    WB_PC4  = 2'd3
  } wb_sel_e;
endpackage

interface write_back_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
);
  import write_back_unit_pkg::*;

  logic                  valid_i;
  logic                  ready_o;
  wb_sel_e               WBSel_i;
  logic [REG_ADDR_W-1:0] rd_addr_i;
  logic [2:0]            funct3_i;
  logic [DATA_WIDTH-1:0] alu_result_i;
  logic [DATA_WIDTH-1:0] pc_plus4_i;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  stall_i;
  logic                  flush_i;
  logic                  wb_we_o;
  logic [REG_ADDR_W-1:0] wb_rd_o;
  logic [DATA_WIDTH-1:0] wb_data_o;
  logic                  err_o;

  // Writeback unit side
  modport slave (
    input  valid_i, WBSel_i, rd_addr_i, funct3_i, alu_result_i, pc_plus4_i,
    input  mem_rvalid_i, mem_rdata_i, stall_i, flush_i,
    output ready_o, wb_we_o, wb_rd_o, wb_data_o, err_o
  );

  // Pipeline / memory / register-file side
  modport master (
    output valid_i, WBSel_i, rd_addr_i, funct3_i, alu_result_i, pc_plus4_i,
    output mem_rvalid_i, mem_rdata_i, stall_i, flush_i,
    input  ready_o, wb_we_o, wb_rd_o, wb_data_o, err_o
  );
endinterface

// File: rtl/write_back_unit.sv
// Registered writeback stage: selects ALU / PC+4 / extracted load data and issues one register-file write.
// Latency: 1 cycle from accept for ALU and PC+4; 1 cycle after mem_rvalid_i for loads.
// Backpressure: ready_o low while a load is outstanding or on stall_i/flush_i; the write port never stalls.
module write_back_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst_n,
  write_back_unit_if.slave bus
);
  import write_back_unit_pkg::*;

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);
  localparam int CNT_W = $clog2(MEM_TIMEOUT);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_e;

  state_e                state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [REG_ADDR_W-1:0] rd_q,      rd_d;
  logic [2:0]            f3_q,      f3_d;
  logic [OFF_W-1:0]      off_q,     off_d;
  logic                  wb_we_q,   wb_we_d;
  logic [REG_ADDR_W-1:0] wb_rd_q,   wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  err_q,     err_d;

  logic                  ready;
  logic                  accept;
  logic [OFF_W-1:0]      off_h;
  logic [OFF_W-1:0]      off_w;
  logic [7:0]            ld_b;
  logic [15:0]           ld_h;
  logic [31:0]           ld_w;
  logic [DATA_WIDTH-1:0] ld_data;

  assign ready  = (state_q == IDLE) & ~bus.stall_i & ~bus.flush_i;
  assign accept = bus.valid_i & ready;

  assign bus.ready_o   = ready;
  assign bus.wb_we_o   = wb_we_q;
  assign bus.wb_rd_o   = wb_rd_q;
  assign bus.wb_data_o = wb_data_q;
  assign bus.err_o     = err_q;

  // Load extraction: pick byte/half/word lane by captured offset (half ignores bit0, word ignores bits 1:0), then extend.
  always_comb begin
    off_h   = off_q & ~OFF_W'(1);
    off_w   = off_q & ~OFF_W'(3);
    ld_b    = bus.mem_rdata_i[{off_q, 3'b000} +: 8];
    ld_h    = bus.mem_rdata_i[{off_h, 3'b000} +: 16];
    ld_w    = bus.mem_rdata_i[{off_w, 3'b000} +: 32];
    ld_data = DATA_WIDTH'($signed(ld_w));
    case (f3_q)
      F3_LB:   ld_data = DATA_WIDTH'($signed(ld_b));
      F3_LBU:  ld_data = DATA_WIDTH'(ld_b);
      F3_LH:   ld_data = DATA_WIDTH'($signed(ld_h));
      F3_LHU:  ld_data = DATA_WIDTH'(ld_h);
      F3_LWU:  if (DATA_WIDTH == 64) ld_data = DATA_WIDTH'(ld_w);
      F3_LD:   if (DATA_WIDTH == 64) ld_data = bus.mem_rdata_i;
      default: ld_data = DATA_WIDTH'($signed(ld_w));
    endcase
  end

  // Next-state: accept in IDLE, then in WAIT_MEM resolve flush > rvalid > timeout > keep counting.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    f3_d      = f3_q;
    off_d     = off_q;
    wb_we_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.WBSel_i)
            WB_ALU: begin
              wb_we_d   = |bus.rd_addr_i;
              wb_rd_d   = bus.rd_addr_i;
              wb_data_d = bus.alu_result_i;
            end
            WB_PC4: begin
              wb_we_d   = |bus.rd_addr_i;
              wb_rd_d   = bus.rd_addr_i;
              wb_data_d = bus.pc_plus4_i;
            end
            WB_MEM: begin
              state_d = WAIT_MEM;
              cnt_d   = '0;
              rd_d    = bus.rd_addr_i;
              f3_d    = bus.funct3_i;
              off_d   = bus.alu_result_i[OFF_W-1:0];
            end
            default: begin
            end
          endcase
        end
      end
      WAIT_MEM: begin
        if (bus.flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bus.mem_rvalid_i) begin
          state_d   = IDLE;
          cnt_d     = '0;
          wb_we_d   = |rd_q;
          wb_rd_d   = rd_q;
          wb_data_d = ld_data;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, load context and all registered outputs; reset abandons any outstanding load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_write_back_unit.sv
// Directed bench for write_back_unit: 32-bit instance for control paths, 64-bit instance for wide loads.
// Latency: outputs sampled 1 time unit after the rising edge; inputs changed at the same point.
// Backpressure: exercises stall_i/flush_i against ready_o and outstanding loads.
module tb_write_back_unit;
  import write_back_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  write_back_unit_if #(.DATA_WIDTH(32), .REG_ADDR_W(5)) b32 ();
  write_back_unit_if #(.DATA_WIDTH(64), .REG_ADDR_W(5)) b64 ();

  write_back_unit #(.DATA_WIDTH(32), .REG_ADDR_W(5), .MEM_TIMEOUT(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(b32)
  );
  write_back_unit #(.DATA_WIDTH(64), .REG_ADDR_W(5), .MEM_TIMEOUT(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(b64)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b32.valid_i = 1'b0; b32.WBSel_i = WB_NONE; b32.rd_addr_i = '0; b32.funct3_i = '0;
    b32.alu_result_i = '0; b32.pc_plus4_i = '0; b32.mem_rvalid_i = 1'b0; b32.mem_rdata_i = '0;
    b32.stall_i = 1'b0; b32.flush_i = 1'b0;
    b64.valid_i = 1'b0; b64.WBSel_i = WB_NONE; b64.rd_addr_i = '0; b64.funct3_i = '0;
    b64.alu_result_i = '0; b64.pc_plus4_i = '0; b64.mem_rvalid_i = 1'b0; b64.mem_rdata_i = '0;
    b64.stall_i = 1'b0; b64.flush_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (b32.wb_we_o !== 1'b0) begin n_fails++; $display("FAIL reset_we: got %b want 0", b32.wb_we_o); end
    n_checks++; if (b32.wb_rd_o !== 5'd0) begin n_fails++; $display("FAIL reset_rd: got %0d want 0", b32.wb_rd_o); end
    n_checks++; if (b32.wb_data_o !== 32'h0) begin n_fails++; $display("FAIL reset_data: got %h want 0", b32.wb_data_o); end
    n_checks++; if (b32.err_o !== 1'b0) begin n_fails++; $display("FAIL reset_err: got %b want 0", b32.err_o); end
    n_checks++; if (b64.wb_data_o !== 64'h0) begin n_fails++; $display("FAIL reset_data64: got %h want 0", b64.wb_data_o); end
    rst_n = 1'b1;
    cyc();
    n_checks++; if (b32.ready_o !== 1'b1) begin n_fails++; $display("FAIL reset_ready: got %b want 1", b32.ready_o); end
  endtask

  task automatic test_alu();
    b32.valid_i = 1'b1; b32.WBSel_i = WB_ALU; b32.rd_addr_i = 5'd5; b32.alu_result_i = 32'hAAAA_AAAA;
    #1;
    n_checks++; if (b32.ready_o !== 1'b1) begin n_fails++; $display("FAIL alu_ready: got %b want 1", b32.ready_o); end
    cyc();
    b32.valid_i = 1'b0; b32.WBSel_i = WB_NONE;
    n_checks++; if (b32.wb_we_o !== 1'b1) begin n_fails++; $display("FAIL alu_we: got %b want 1", b32.wb_we_o); end
    n_checks++; if (b32.wb_rd_o !== 5'd5) begin n_fails++; $display("FAIL alu_rd: got %0d want 5", b32.wb_rd_o); end
    n_checks++; if (b32.wb_data_o !== 32'hAAAA_AAAA) begin n_fails++; $display("FAIL alu_data: got %h want aaaaaaaa", b32.wb_data_o); end
    cyc();
    n_checks++; if (b32.wb_we_o !== 1'b0) begin n_fails++; $display("FAIL alu_we_pulse: got %b want 0", b32.wb_we_o); end
  endtask

  task automatic test_back_to_back();
    b32.valid_i = 1'b1; b32.WBSel_i = WB_PC4; b32.rd_addr_i = 5'd1; b32.pc_plus4_i = 32'hCCCC_CCCC;
    b32.alu_result_i = 32'h1111_1111;
    cyc();
    b32.WBSel_i = WB_ALU; b32.rd_addr_i = 5'd0; b32.alu_result_i = 32'h1234_5678;
    n_checks++; if (b32.wb_we_o !== 1'b1) begin n_fails++; $display("FAIL b2b_pc4_we: got %b want 1", b32.wb_we_o); end
    n_checks++; if (b32.wb_rd_o !== 5'd1) begin n_fails++; $display("FAIL b2b_pc4_rd: got %0d want 1", b32.wb_rd_o); end
    n_checks++; if (b32.wb_data_o !== 32'hCCCC_CCCC) begin n_fails++; $display("FAIL b2b_pc4_data: got %h want cccccccc", b32.wb_data_o); end
    cyc();
    b32.rd_addr_i = 5'd3; b32.alu_result_i = 32'h0000_0055;
    n_checks++; if (b32.wb_we_o !== 1'b0) begin n_fails++; $display("FAIL b2b_rd0_we: got %b want 0", b32.wb_we_o); end
    cyc();
    b32.WBSel_i = WB_NONE; b32.rd_addr_i = 5'd9; b32.alu_result_i = 32'h0000_0099;
    n_checks++; if (b32.wb_data_o !== 32'h0000_0055) begin n_fails++; $display("FAIL b2b_alu3_data: got %h want 00000055", b32.wb_data_o); end
    cyc();
    b32.valid_i = 1'b0;
    n_checks++; if (b32.wb_we_o !== 1'b0) begin n_fails++; $display("FAIL none_we: got %b want 0", b32.wb_we_o); end
    n_checks++; if (b32.wb_rd_o !== 5'd3) begin n_fails++; $display("FAIL none_rd_hold: got %0d want 3", b32.wb_rd_o); end
    n_checks++; if (b32.wb_data_o !== 32'h0000_0055) begin n_fails++; $display("FAIL none_data_hold: got %h want 00000055", b32.wb_data_o); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [5] = '{3'b000, 3'b101, 3'b001, 3'b010, 3'b111};
    logic [1:0]  off [5] = '{2'd2, 2'd2, 2'd1, 2'd0, 2'd3};
    logic [4:0]  rd  [5] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
    logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_1280, 32'hFFFF_FF34, 32'h1280_FF34, 32'h1280_FF34};
    for (int i = 0; i < 5; i++) begin
      b32.valid_i = 1'b1; b32.WBSel_i = WB_MEM; b32.funct3_i = f3[i]; b32.rd_addr_i = rd[i];
      b32.alu_result_i = {30'h0400_0000, off[i]};
      cyc();
      b32.valid_i = 1'b0; b32.WBSel_i = WB_NONE;
      for (int w = 0; w < 2; w++) begin
        #1;
        n_checks++; if (b32.ready_o !== 1'b0) begin n_fails++; $display("FAIL load%0d_wait_ready: got %b want 0", i, b32.ready_o); end
        n_checks++; if (b32.wb_we_o !== 1'b0) begin n_fails++; $display("FAIL load%0d_wait_we: got %b want 0", i, b32.wb_we_o); end
        cyc();
      end
      b32.mem_rvalid_i = 1'b1; b32.mem_rdata_i = 32'h1280_FF34;
      cyc();
      b32.mem_rvalid_i = 1'b0; b32.mem_rdata_i = 32'h0;
      n_checks++; if (b32.wb_we_o !== 1'b1) begin n_fails++; $display("FAIL load%0d_we: got %b want 1", i, b32.wb_we_o); end
      n_checks++; if (b32.wb_rd_o !== rd[i]) begin n_fails++; $display("FAIL load%0d_rd: got %0d want %0d", i, b32.wb_rd_o, rd[i]); end
      n_checks++; if (b32.wb_data_o !== exp[i]) begin n_fails++; $display("FAIL load%0d_data: got %h want %h", i, b32.wb_data_o, exp[i]); end
      #1;
      n_checks++; if (b32.ready_o !== 1'b1) begin n_fails++; $display("FAIL load%0d_ready_after: got %b want 1", i, b32.ready_o); end
    end
  endtask

  task automatic test_stall();
    b32.stall_i = 1'b1; b32.valid_i = 1'b1; b32.WBSel_i = WB_ALU; b32.rd_addr_i = 5'd6; b32.alu_result_i = 32'h66;
    #1;
    n_checks++; if (b32.ready_o !== 1'b0) begin n_fails++; $display("FAIL stall_ready: got %b want 0", b32.ready_o); end
    cyc();
    n_checks++; if (b32.wb_we_o !== 1'b0) begin n_fails++; $display("FAIL stall_no_accept: got %b want 0", b32.wb_we_o); end
    b32.stall_i = 1'b0;
    cyc();
    b32.valid_i = 1'b0; b32.WBSel_i = WB_NONE;
    n_checks++; if (b32.wb_data_o !== 32'h66 || b32.wb_we_o !== 1'b1) begin n_fails++; $display("FAIL stall_release: got we=%b data=%h want we=1 data=00000066", b32.wb_we_o, b32.wb_data_o); end
    // LBU at offset 3, stall held during the response
    b32.valid_i = 1'b1; b32.WBSel_i = WB_MEM; b32.funct3_i = 3'b100; b32.rd_addr_i = 5'd8; b32.alu_result_i = 32'h3;
    cyc();
    b32.valid_i = 1'b0; b32.WBSel_i = WB_NONE; b32.stall_i = 1'b1;
    b32.mem_rvalid_i = 1'b1; b32.mem_rdata_i = 32'h1280_FF34;
    cyc();
    b32.stall_i = 1'b0; b32.mem_rvalid_i = 1'b0;
    n_checks++; if (b32.wb_we_o !== 1'b1) begin n_fails++; $display("FAIL stall_load_we: got %b want 1", b32.wb_we_o); end
    n_checks++; if (b32.wb_data_o !== 32'h0000_0012) begin n_fails++; $display("FAIL stall_load_data: got %h want 00000012", b32.wb_data_o); end
  endtask

  task automatic test_flush();
    b32.valid_i = 1'b1; b32.WBSel_i = WB_MEM; b32.funct3_i = 3'b010; b32.rd_addr_i = 5'd4; b32.alu_result_i = 32'h0;
    cyc();
    b32.valid_i = 1'b0; b32.WBSel_i = WB_NONE; b32.flush_i = 1'b1;
    #1;
    n_checks++; if (b32.ready_o !== 1'b0) begin n_fails++; $display("FAIL flush_ready_low: got %b want 0", b32.ready_o); end
    cyc();
    b32.flush_i = 1'b0;
    #1;
    n_checks++; if (b32.ready_o !== 1'b1) begin n_fails++; $display("FAIL flush_ready_idle: got %b want 1", b32.ready_o); end
    cyc();
    b32.mem_rvalid_i = 1'b1; b32.mem_rdata_i = 32'hDEAD_BEEF;
    cyc();
    b32.mem_rvalid_i = 1'b0;
    n_checks++; if (b32.wb_we_o !== 1'b0) begin n_fails++; $display("FAIL flush_stray_we: got %b want 0", b32.wb_we_o); end
    n_checks++; if (b32.err_o !== 1'b0) begin n_fails++; $display("FAIL flush_err: got %b want 0", b32.err_o); end
    n_checks++; if (b32.wb_data_o !== 32'h0000_0012) begin n_fails++; $display("FAIL flush_data_hold: got %h want 00000012", b32.wb_data_o); end
    // flush and rvalid in the same cycle: flush wins
    b32.valid_i = 1'b1; b32.WBSel_i = WB_MEM; b32.rd_addr_i = 5'd9;
    cyc();
    b32.valid_i = 1'b0; b32.WBSel_i = WB_NONE; b32.flush_i = 1'b1; b32.mem_rvalid_i = 1'b1;
    cyc();
    b32.flush_i = 1'b0; b32.mem_rvalid_i = 1'b0;
    n_checks++; if (b32.wb_we_o !== 1'b0) begin n_fails++; $display("FAIL flush_prio_we: got %b want 0", b32.wb_we_o); end
    #1;
    n_checks++; if (b32.ready_o !== 1'b1) begin n_fails++; $display("FAIL flush_prio_ready: got %b want 1", b32.ready_o); end
  endtask

  task automatic test_timeout();
    b32.valid_i = 1'b1; b32.WBSel_i = WB_MEM; b32.funct3_i = 3'b010; b32.rd_addr_i = 5'd15; b32.alu_result_i = 32'h0;
    cyc();
    b32.valid_i = 1'b0; b32.WBSel_i = WB_NONE;
    repeat (15) cyc();
    n_checks++; if (b32.err_o !== 1'b0) begin n_fails++; $display("FAIL timeout_early_err: got %b want 0", b32.err_o); end
    n_checks++; if (b32.ready_o !== 1'b0) begin n_fails++; $display("FAIL timeout_early_ready: got %b want 0", b32.ready_o); end
    cyc();
    n_checks++; if (b32.err_o !== 1'b1) begin n_fails++; $display("FAIL timeout_err: got %b want 1", b32.err_o); end
    n_checks++; if (b32.wb_we_o !== 1'b0) begin n_fails++; $display("FAIL timeout_we: got %b want 0", b32.wb_we_o); end
    n_checks++; if (b32.ready_o !== 1'b1) begin n_fails++; $display("FAIL timeout_ready: got %b want 1", b32.ready_o); end
    b32.valid_i = 1'b1; b32.WBSel_i = WB_ALU; b32.rd_addr_i = 5'd2; b32.alu_result_i = 32'h22;
    cyc();
    b32.valid_i = 1'b0; b32.WBSel_i = WB_NONE;
    n_checks++; if (b32.wb_we_o !== 1'b1) begin n_fails++; $display("FAIL timeout_then_alu_we: got %b want 1", b32.wb_we_o); end
    n_checks++; if (b32.err_o !== 1'b1) begin n_fails++; $display("FAIL timeout_sticky: got %b want 1", b32.err_o); end
  endtask

  task automatic test_reset_midload();
    b32.valid_i = 1'b1; b32.WBSel_i = WB_MEM; b32.funct3_i = 3'b010; b32.rd_addr_i = 5'd16;
    cyc();
    b32.valid_i = 1'b0; b32.WBSel_i = WB_NONE;
    #1;
    n_checks++; if (b32.ready_o !== 1'b0) begin n_fails++; $display("FAIL midload_waiting: got %b want 0", b32.ready_o); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (b32.wb_data_o !== 32'h0 || b32.wb_rd_o !== 5'd0 || b32.wb_we_o !== 1'b0) begin
      n_fails++; $display("FAIL midload_outputs: got we=%b rd=%0d data=%h want all 0", b32.wb_we_o, b32.wb_rd_o, b32.wb_data_o); end
    n_checks++; if (b32.err_o !== 1'b0) begin n_fails++; $display("FAIL midload_err: got %b want 0", b32.err_o); end
    cyc();
    rst_n = 1'b1;
    cyc();
    b32.mem_rvalid_i = 1'b1; b32.mem_rdata_i = 32'hFFFF_FFFF;
    cyc();
    b32.mem_rvalid_i = 1'b0;
    n_checks++; if (b32.wb_we_o !== 1'b0) begin n_fails++; $display("FAIL midload_stray_we: got %b want 0", b32.wb_we_o); end
    n_checks++; if (b32.ready_o !== 1'b1) begin n_fails++; $display("FAIL midload_ready: got %b want 1", b32.ready_o); end
  endtask

  task automatic test_load64();
    logic [2:0]  f3  [5] = '{3'b110, 3'b010, 3'b011, 3'b000, 3'b101};
    logic [2:0]  off [5] = '{3'd4, 3'd4, 3'd0, 3'd7, 3'd6};
    logic [63:0] exp [5] = '{64'h0000_0000_8000_0001, 64'hFFFF_FFFF_8000_0001, 64'h8000_0001_1234_5678,
                             64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_8000};
    for (int i = 0; i < 5; i++) begin
      b64.valid_i = 1'b1; b64.WBSel_i = WB_MEM; b64.funct3_i = f3[i]; b64.rd_addr_i = 5'd7;
      b64.alu_result_i = {61'h0, off[i]};
      cyc();
      b64.valid_i = 1'b0; b64.WBSel_i = WB_NONE;
      b64.mem_rvalid_i = 1'b1; b64.mem_rdata_i = 64'h8000_0001_1234_5678;
      cyc();
      b64.mem_rvalid_i = 1'b0;
      n_checks++; if (b64.wb_we_o !== 1'b1) begin n_fails++; $display("FAIL load64_%0d_we: got %b want 1", i, b64.wb_we_o); end
      n_checks++; if (b64.wb_data_o !== exp[i]) begin n_fails++; $display("FAIL load64_%0d_data: got %h want %h", i, b64.wb_data_o, exp[i]); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_alu();
    test_back_to_back();
    test_loads();
    test_stall();
    test_flush();
    test_timeout();
    test_reset_midload();
    test_load64();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
